wb_regfile_sb: RTL and testbench
================================

WB_REGFILE_SB -- requirements
Module: wb_regfile_sb

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have port: aresetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: wb0_wRegEn  in  1 / wb0_wRegAddr  in  5 / wb0_wRegData  in  32  main-pipe writeback.
REQ-004 SHALL have ports: wb1_wRegEn  in  1 / wb1_wRegAddr  in  5 / wb1_wRegData  in  32  lite-pipe writeback, driven from the mem_wb_lite register outputs.
REQ-005 SHALL have ports: rd0_addr, rd1_addr  in  5  read addresses.
REQ-006 SHALL have ports: rd0_data, rd1_data  out  32  read data, combinational.
REQ-007 SHALL have ports: rd0_busy, rd1_busy  out  1  source has an outstanding write; consumer must stall.
REQ-008 SHALL have ports: iss_valid  in  1 / iss_wRegEn  in  1 / iss_wRegAddr  in  5  issue of an instruction with a destination.
REQ-009 SHALL have port: iss_ready  out  1  issue accepted this cycle.
REQ-010 SHALL have port: flush  in  1  discard all outstanding (not yet written back) destinations.

Function
REQ-011 SHALL hold 32 x 32-bit GPRs; r0 reads 0 always; writes to r0 ignored; r0 never pending.
REQ-012 SHALL write gpr[wbN_wRegAddr] <= wbN_wRegData on posedge when wbN_wRegEn=1 and addr!=0.
REQ-013 SHALL, when both ports write the same nonzero addr in one cycle, store wb1 data (lite pipe is younger).
REQ-014 SHALL bypass: rdK_data = wb1_wRegData if wb1 writes rdK_addr this cycle, else wb0_wRegData if wb0 writes it, else gpr[rdK_addr]; rdK_addr=0 -> 0.
REQ-015 SHALL keep a 2-bit pending counter per register (r1..r31).
REQ-016 SHALL assert iss_ready = !(iss_wRegEn && iss_wRegAddr!=0 && cnt[iss_wRegAddr]==3); issue fires when iss_valid && iss_ready.
REQ-017 SHALL, per register per cycle, compute next cnt = cnt + inc - dec, inc = fired issue with iss_wRegEn to that reg (0/1), dec = count of wb ports with en writing that reg (0..2).
REQ-018 SHALL clamp cnt at 0 on underflow (stray writeback); no wrap.
REQ-019 SHALL assert rdK_busy = (rdK_addr!=0) && (cnt[rdK_addr] - dec_this_cycle[rdK_addr] > 0), evaluated combinationally with the clamp.
REQ-020 SHALL not reflect a same-cycle issue in rdK_busy (issue visible from next cycle).
REQ-021 SHALL, on flush=1, zero all counters next cycle, ignoring same-cycle issue increments; gpr writes from wb ports that cycle still occur.
REQ-022 SHALL, with iss_valid=0 or iss_wRegEn=0, leave counters affected only by writebacks.

Reset
REQ-023 SHALL, when aresetn=0 at posedge, clear all gpr to 0 and all counters to 0; wb writes and issue that cycle are ignored.
REQ-024 SHALL, during reset, present rdK_data from bypass/gpr per REQ-014 and iss_ready=1; gpr and counters hold 0 until aresetn=1.
REQ-025 SHALL apply reset over flush and over any operation in progress.

Verification
REQ-026 SHALL test: wb0 writes r5=0x11111111 and wb1 writes r5=0x22222222 same cycle, rd0_addr=5 -> rd0_data=0x22222222 that cycle, gpr[5]=0x22222222 after.
REQ-027 SHALL test: issue dest r7, next cycle rd1_addr=7 -> rd1_busy=1; cycle wb1 writes r7=0xABCD0000 -> rd1_busy=0, rd1_data=0xABCD0000.
REQ-028 SHALL test: three issues to r3 -> cnt=3, fourth issue to r3 -> iss_ready=0; a wb0 write to r3 -> cnt=2, iss_ready=1.
REQ-029 SHALL test: issue to r9 and flush same cycle -> cnt[9]=0 next cycle, rd0_busy=0.
REQ-030 SHALL test: wb0 writes r0=0xFFFFFFFF, issue dest r0 -> rd0_data=0, rd0_busy=0, iss_ready=1.
REQ-031 SHALL test: r4 written 0x5, cnt[4]=1, aresetn=0 for one cycle -> rd0_data(r4)=0, rd0_busy=0 after.

Source files
------------

// File: rtl/wb_regfile_sb.sv
// Dual-writeback 32x32 register file with a per-register pending-write
// scoreboard. Reads bypass same-cycle writebacks (lite pipe wins over main);
// each r1..r31 keeps a saturating 2-bit count of outstanding destinations.
module wb_regfile_sb (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        wb0_wRegEn,
  input  logic [4:0]  wb0_wRegAddr,
  input  logic [31:0] wb0_wRegData,
  input  logic        wb1_wRegEn,
  input  logic [4:0]  wb1_wRegAddr,
  input  logic [31:0] wb1_wRegData,
  input  logic [4:0]  rd0_addr,
  input  logic [4:0]  rd1_addr,
  output logic [31:0] rd0_data,
  output logic [31:0] rd1_data,
  output logic        rd0_busy,
  output logic        rd1_busy,
  input  logic        iss_valid,
  input  logic        iss_wRegEn,
  input  logic [4:0]  iss_wRegAddr,
  output logic        iss_ready,
  input  logic        flush
);

  logic [31:0] gpr     [32];
  logic [1:0]  cnt     [32];
  logic [1:0]  dec     [32];
  logic [1:0]  cnt_nxt [32];
  logic        wb0_act;
  logic        wb1_act;
  logic        iss_fire;
  logic        hit0;
  logic        hit1;
  logic        inc;
  logic [2:0]  sum;

  assign wb0_act = wb0_wRegEn && (wb0_wRegAddr != '0);
  assign wb1_act = wb1_wRegEn && (wb1_wRegAddr != '0);

  // Issue is refused only when its destination counter is already saturated
  always_comb begin
    iss_ready = 1'b1;
    if (aresetn && iss_wRegEn && (iss_wRegAddr != '0) && (cnt[iss_wRegAddr] == 2'd3))
      iss_ready = 1'b0;
    iss_fire = iss_valid && iss_ready && iss_wRegEn && (iss_wRegAddr != '0);
  end

  // Per-register writeback decrement and next counter value (clamped at 0)
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    inc  = 1'b0;
    sum  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      hit0       = wb0_act && (wb0_wRegAddr == 5'(i));
      hit1       = wb1_act && (wb1_wRegAddr == 5'(i));
      inc        = iss_fire && (iss_wRegAddr == 5'(i));
      dec[i]     = {1'b0, hit0} + {1'b0, hit1};
      sum        = {1'b0, cnt[i]} + {2'b00, inc};
      cnt_nxt[i] = '0;
      if (!flush && (i != 0) && (sum > {1'b0, dec[i]}))
        cnt_nxt[i] = 2'(sum - {1'b0, dec[i]});
    end
  end

  // Read port 0: bypass lite pipe, then main pipe, then array
  always_comb begin
    rd0_data = gpr[rd0_addr];
    if (wb0_act && (wb0_wRegAddr == rd0_addr)) rd0_data = wb0_wRegData;
    if (wb1_act && (wb1_wRegAddr == rd0_addr)) rd0_data = wb1_wRegData;
    if (rd0_addr == '0)                        rd0_data = '0;
    rd0_busy = (rd0_addr != '0) && (cnt[rd0_addr] > dec[rd0_addr]);
  end

  // Read port 1: same priority as port 0
  always_comb begin
    rd1_data = gpr[rd1_addr];
    if (wb0_act && (wb0_wRegAddr == rd1_addr)) rd1_data = wb0_wRegData;
    if (wb1_act && (wb1_wRegAddr == rd1_addr)) rd1_data = wb1_wRegData;
    if (rd1_addr == '0)                        rd1_data = '0;
    rd1_busy = (rd1_addr != '0) && (cnt[rd1_addr] > dec[rd1_addr]);
  end

  // Register array and scoreboard update; wb1 written last so it wins a collision
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < 32; i++) begin
        gpr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (wb0_act) gpr[wb0_wRegAddr] <= wb0_wRegData;
      if (wb1_act) gpr[wb1_wRegAddr] <= wb1_wRegData;
      for (int unsigned i = 0; i < 32; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: bypass priority, scoreboard saturation,
// flush, r0 handling and synchronous reset.
module tb_wb_regfile_sb;

  logic        clk;
  logic        aresetn;
  logic        wb0_wRegEn;
  logic [4:0]  wb0_wRegAddr;
  logic [31:0] wb0_wRegData;
  logic        wb1_wRegEn;
  logic [4:0]  wb1_wRegAddr;
  logic [31:0] wb1_wRegData;
  logic [4:0]  rd0_addr;
  logic [4:0]  rd1_addr;
  logic [31:0] rd0_data;
  logic [31:0] rd1_data;
  logic        rd0_busy;
  logic        rd1_busy;
  logic        iss_valid;
  logic        iss_wRegEn;
  logic [4:0]  iss_wRegAddr;
  logic        iss_ready;
  logic        flush;

  int unsigned n_checks;
  int unsigned n_fails;

  wb_regfile_sb dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .wb0_wRegEn   (wb0_wRegEn),
    .wb0_wRegAddr (wb0_wRegAddr),
    .wb0_wRegData (wb0_wRegData),
    .wb1_wRegEn   (wb1_wRegEn),
    .wb1_wRegAddr (wb1_wRegAddr),
    .wb1_wRegData (wb1_wRegData),
    .rd0_addr     (rd0_addr),
    .rd1_addr     (rd1_addr),
    .rd0_data     (rd0_data),
    .rd1_data     (rd1_data),
    .rd0_busy     (rd0_busy),
    .rd1_busy     (rd1_busy),
    .iss_valid    (iss_valid),
    .iss_wRegEn   (iss_wRegEn),
    .iss_wRegAddr (iss_wRegAddr),
    .iss_ready    (iss_ready),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs change 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wb0_wRegEn = 1'b0; wb0_wRegAddr = '0; wb0_wRegData = '0;
    wb1_wRegEn = 1'b0; wb1_wRegAddr = '0; wb1_wRegData = '0;
    iss_valid  = 1'b0; iss_wRegEn   = 1'b0; iss_wRegAddr = '0;
    flush      = 1'b0;
  endtask

  task automatic wb0(input logic [4:0] a, input logic [31:0] d);
    wb0_wRegEn = 1'b1; wb0_wRegAddr = a; wb0_wRegData = d;
  endtask

  task automatic wb1(input logic [4:0] a, input logic [31:0] d);
    wb1_wRegEn = 1'b1; wb1_wRegAddr = a; wb1_wRegData = d;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1'b1; iss_wRegEn = 1'b1; iss_wRegAddr = a;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle();
    aresetn  = 1'b0;
    rd0_addr = 5'd5;
    rd1_addr = 5'd0;
    tick();
    tick();
    settle();
    check("rst_iss_ready", 32'(iss_ready), 32'd1);
    check("rst_rd0_data", rd0_data, 32'h0);
    aresetn = 1'b1;
    tick();
    settle();
    check("post_rst_rd0_data", rd0_data, 32'h0);
    check("post_rst_rd0_busy", 32'(rd0_busy), 32'd0);

    // Same-address collision: lite pipe is younger and wins
    wb0(5'd5, 32'h1111_1111);
    wb1(5'd5, 32'h2222_2222);
    rd0_addr = 5'd5;
    rd1_addr = 5'd5;
    settle();
    check("collide_bypass_rd0", rd0_data, 32'h2222_2222);
    check("collide_bypass_rd1", rd1_data, 32'h2222_2222);
    tick();
    idle();
    wb0(5'd6, 32'h0000_600D);
    rd1_addr = 5'd6;
    settle();
    check("collide_stored", rd0_data, 32'h2222_2222);
    check("wb0_bypass_rd1", rd1_data, 32'h0000_600D);
    tick();
    idle();
    settle();
    check("wb0_stored_r6", rd1_data, 32'h0000_600D);

    // Issue r7: invisible same cycle, busy next, cleared by wb1 writeback
    issue(5'd7);
    rd1_addr = 5'd7;
    settle();
    check("iss_r7_same_cycle_busy", 32'(rd1_busy), 32'd0);
    check("iss_r7_ready", 32'(iss_ready), 32'd1);
    tick();
    idle();
    settle();
    check("r7_busy", 32'(rd1_busy), 32'd1);
    wb1(5'd7, 32'hABCD_0000);
    settle();
    check("r7_wb_busy", 32'(rd1_busy), 32'd0);
    check("r7_wb_data", rd1_data, 32'hABCD_0000);
    tick();
    idle();
    settle();
    check("r7_after_busy", 32'(rd1_busy), 32'd0);

    // Saturate r3 at three outstanding issues
    rd0_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      issue(5'd3);
      settle();
      check("r3_issue_ready", 32'(iss_ready), 32'd1);
      tick();
    end
    issue(5'd3);
    settle();
    check("r3_full_ready", 32'(iss_ready), 32'd0);
    check("r3_full_busy", 32'(rd0_busy), 32'd1);
    tick();
    idle();
    wb0(5'd3, 32'h0000_0033);
    settle();
    check("r3_wb_still_busy", 32'(rd0_busy), 32'd1);
    tick();
    idle();
    iss_wRegEn   = 1'b1;
    iss_wRegAddr = 5'd3;
    settle();
    check("r3_cnt2_ready", 32'(iss_ready), 32'd1);
    check("r3_cnt2_busy", 32'(rd0_busy), 32'd1);
    tick();
    idle();
    wb0(5'd3, 32'h0000_0030);
    wb1(5'd3, 32'h0000_0031);
    settle();
    check("r3_dual_wb_busy", 32'(rd0_busy), 32'd0);
    check("r3_dual_wb_data", rd0_data, 32'h0000_0031);
    tick();
    idle();
    wb0(5'd3, 32'h0000_0032);
    tick();
    idle();
    iss_wRegEn   = 1'b1;
    iss_wRegAddr = 5'd3;
    settle();
    check("r3_underflow_ready", 32'(iss_ready), 32'd1);
    check("r3_underflow_busy", 32'(rd0_busy), 32'd0);
    check("r3_stray_wb_data", rd0_data, 32'h0000_0032);
    tick();
    idle();

    // Flush discards an older pending dest and a same-cycle issue
    issue(5'd10);
    tick();
    idle();
    issue(5'd9);
    flush = 1'b1;
    wb0(5'd10, 32'h0000_0F00);
    tick();
    idle();
    rd0_addr = 5'd9;
    rd1_addr = 5'd10;
    settle();
    check("flush_r9_busy", 32'(rd0_busy), 32'd0);
    check("flush_r10_busy", 32'(rd1_busy), 32'd0);
    check("flush_r10_written", rd1_data, 32'h0000_0F00);

    // r0 never written and never pending
    wb0(5'd0, 32'hFFFF_FFFF);
    issue(5'd0);
    rd0_addr = 5'd0;
    settle();
    check("r0_data", rd0_data, 32'h0);
    check("r0_busy", 32'(rd0_busy), 32'd0);
    check("r0_iss_ready", 32'(iss_ready), 32'd1);
    tick();
    idle();
    settle();
    check("r0_data_after", rd0_data, 32'h0);
    check("r0_busy_after", 32'(rd0_busy), 32'd0);

    // Reset clears both array and scoreboard
    rd0_addr = 5'd4;
    wb0(5'd4, 32'h0000_0005);
    tick();
    idle();
    issue(5'd4);
    tick();
    idle();
    settle();
    check("r4_data", rd0_data, 32'h0000_0005);
    check("r4_busy", 32'(rd0_busy), 32'd1);
    aresetn = 1'b0;
    wb0(5'd4, 32'h0000_0077);
    issue(5'd4);
    flush = 1'b1;
    settle();
    check("rst_bypass_r4", rd0_data, 32'h0000_0077);
    check("rst_ready_r4", 32'(iss_ready), 32'd1);
    tick();
    idle();
    aresetn = 1'b1;
    settle();
    check("r4_after_rst_data", rd0_data, 32'h0);
    check("r4_after_rst_busy", 32'(rd0_busy), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
